// File: rtl/lamp_fpu_sqrt_round_out.sv
// lamp_fpu_sqrt_round_out: rounds and packs sqrt results to BFloat16 and buffers them in a FIFO.
// Define LAMP_SQRT_RND_MODES_EN to add rnd_mode_i (RNE/RTZ/RUP/RDN); otherwise RNE only.
module lamp_fpu_sqrt_round_out #(
    parameter int FIFO_DEPTH = 2,
    parameter int E_DW = 8,
    parameter int F_DW = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic                 s_i,
    input  logic [E_DW-1:0]      e_i,
    input  logic [F_DW+4:0]      f_i,
    input  logic                 isToRound_i,
    input  logic                 isOverflow_i,
    input  logic                 isUnderflow_i,
`ifdef LAMP_SQRT_RND_MODES_EN
    input  logic [1:0]           rnd_mode_i,
`endif
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [E_DW+F_DW:0]   result_o,
    output logic [2:0]           flags_o,
    output logic                 drop_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [F_DW:0] mant;
    logic g, st, inc, maxFin;
    assign mant = f_i[F_DW+4:4];
    assign g = f_i[3];
    assign st = |f_i[2:0];
`ifdef LAMP_SQRT_RND_MODES_EN
    assign inc = rnd_mode_i == 2'd0 ? g & (st | mant[0]) :
                 rnd_mode_i == 2'd1 ? 1'b0 :
                 rnd_mode_i == 2'd2 ? (g | st) & ~s_i : (g | st) & s_i;
    // Overflow saturates to max-finite when rounding direction points away from infinity
    assign maxFin = rnd_mode_i == 2'd1 | (rnd_mode_i == 2'd2 & s_i) | (rnd_mode_i == 2'd3 & ~s_i);
`else
    assign inc = g & (st | mant[0]);
    assign maxFin = 1'b0;
`endif

    logic v1, v2, s1, gs1, tr1, ov1, un1, mf1;
    logic [E_DW-1:0] e1;
    logic [F_DW+1:0] sum1;
    logic [E_DW+F_DW:0] res2, res2n;
    logic [2:0] flg2, flg2n;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= valid_i;
            v2 <= v1;
        end
    end

    always_ff @(posedge clk) begin
        s1 <= s_i;
        e1 <= e_i;
        sum1 <= isToRound_i ? {1'b0, mant} + {{(F_DW+1){1'b0}}, inc} : {1'b0, mant};
        gs1 <= g | st;
        tr1 <= isToRound_i;
        ov1 <= isOverflow_i;
        un1 <= isUnderflow_i;
        mf1 <= maxFin;
        res2 <= res2n;
        flg2 <= flg2n;
    end

    logic [E_DW-1:0] eRnd;
    logic ovfRnd;
    assign eRnd = e1 + {{(E_DW-1){1'b0}}, sum1[F_DW+1]};
    assign ovfRnd = eRnd == {E_DW{1'b1}};
    assign res2n = !tr1 ? {s1, e1, sum1[F_DW-1:0]} :
                   ovfRnd ? {s1, mf1 ? {{(E_DW-1){1'b1}}, 1'b0} : {E_DW{1'b1}}, {F_DW{mf1}}} :
                   {s1, eRnd, sum1[F_DW+1] ? {F_DW{1'b0}} : sum1[F_DW-1:0]};
    assign flg2n = tr1 ? {ovfRnd | ov1, un1, gs1} : 3'b000;

    logic [E_DW+F_DW:0] memR [FIFO_DEPTH];
    logic [2:0] memF [FIFO_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [CW-1:0] cnt;
    logic full, pop, push;
    assign full = cnt == CW'(FIFO_DEPTH);
    assign pop = valid_o & ready_i;
    // When full, the slot being popped is the one written, so push+pop is safe
    assign push = v2 & (!full | pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            drop_o <= 1'b0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
            if (v2 & full & !pop) drop_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            memR[wp] <= res2;
            memF[wp] <= flg2;
        end
    end

    assign valid_o = cnt != '0;
    assign result_o = valid_o ? memR[rp] : '0;
    assign flags_o = valid_o ? memF[rp] : 3'b000;
endmodule

// File: tb/tb_lamp_fpu_sqrt_round_out.sv
// tb_lamp_fpu_sqrt_round_out: directed vector bench for the sqrt round/pack/FIFO stage.
module tb_lamp_fpu_sqrt_round_out;
    logic clk = 1'b0, rst = 1'b1, valid_i = 1'b0, s_i = 1'b0, ready_i = 1'b1;
    logic isToRound_i = 1'b0, isOverflow_i = 1'b0, isUnderflow_i = 1'b0;
    logic [7:0] e_i = '0;
    logic [11:0] f_i = '0;
    logic valid_o, drop_o;
    logic [15:0] result_o;
    logic [2:0] flags_o;
`ifdef LAMP_SQRT_RND_MODES_EN
    logic [1:0] rnd_mode_i = 2'd0;
`endif
    int nVec = 0, nErr = 0;

    always #5 clk = ~clk;

    lamp_fpu_sqrt_round_out dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .s_i(s_i), .e_i(e_i), .f_i(f_i),
        .isToRound_i(isToRound_i), .isOverflow_i(isOverflow_i), .isUnderflow_i(isUnderflow_i),
`ifdef LAMP_SQRT_RND_MODES_EN
        .rnd_mode_i(rnd_mode_i),
`endif
        .ready_i(ready_i), .valid_o(valid_o), .result_o(result_o), .flags_o(flags_o), .drop_o(drop_o)
    );

    typedef struct {
        logic s;
        logic [7:0] e;
        logic [11:0] f;
        logic tr, ov, un;
        logic [15:0] res;
        logic [2:0] flg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        s_i = v.s; e_i = v.e; f_i = v.f;
        isToRound_i = v.tr; isOverflow_i = v.ov; isUnderflow_i = v.un;
        valid_i = 1'b1;
    endtask

    task automatic apply(input int i, input vec_t v);
        @(negedge clk) drive(v);
        @(posedge clk) #1 chk($sformatf("v%0d valid N", i), 32'(valid_o), 0);
        @(negedge clk) valid_i = 1'b0;
        @(posedge clk) #1 chk($sformatf("v%0d valid N+1", i), 32'(valid_o), 0);
        @(posedge clk) #1;
        chk($sformatf("v%0d valid N+2", i), 32'(valid_o), 1);
        chk($sformatf("v%0d result", i), 32'(result_o), 32'(v.res));
        chk($sformatf("v%0d flags", i), 32'(flags_o), 32'(v.flg));
    endtask

    task automatic burst(input vec_t a, input vec_t b, input vec_t c);
        @(negedge clk) drive(a);
        @(negedge clk) drive(b);
        @(negedge clk) drive(c);
    endtask

    vec_t tv [14];
    vec_t A, B, C;

    initial begin
        tv[0]  = '{0, 8'h80, 12'h800, 1, 0, 0, 16'h4000, 3'b000};
        tv[1]  = '{0, 8'h7F, 12'h818, 1, 0, 0, 16'h3F82, 3'b001};
        tv[2]  = '{0, 8'h7F, 12'h808, 1, 0, 0, 16'h3F80, 3'b001};
        tv[3]  = '{0, 8'h7F, 12'hFF8, 1, 0, 0, 16'h4000, 3'b001};
        tv[4]  = '{0, 8'hFE, 12'hFF8, 1, 0, 0, 16'h7F80, 3'b101};
        tv[5]  = '{0, 8'hFF, 12'hC00, 0, 0, 0, 16'h7FC0, 3'b000};
        tv[6]  = '{1, 8'h00, 12'h000, 0, 0, 0, 16'h8000, 3'b000};
        tv[7]  = '{0, 8'h7F, 12'h814, 1, 0, 0, 16'h3F81, 3'b001};
        tv[8]  = '{1, 8'h7F, 12'h80C, 1, 0, 0, 16'hBF81, 3'b001};
        tv[9]  = '{0, 8'h85, 12'hA00, 1, 1, 0, 16'h42A0, 3'b100};
        tv[10] = '{0, 8'h01, 12'h900, 1, 0, 1, 16'h0090, 3'b010};
        tv[11] = '{0, 8'hFF, 12'h80F, 0, 1, 0, 16'h7F80, 3'b000};
        tv[12] = '{0, 8'hFF, 12'h800, 1, 0, 0, 16'h7F80, 3'b100};
        tv[13] = '{0, 8'h7F, 12'h828, 1, 0, 0, 16'h3F82, 3'b001};
        A = '{0, 8'h80, 12'h800, 1, 0, 0, 16'h4000, 3'b000};
        B = '{0, 8'h7F, 12'h818, 1, 0, 0, 16'h3F82, 3'b001};
        C = '{1, 8'h00, 12'h000, 0, 0, 0, 16'h8000, 3'b000};

        valid_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", 32'(valid_o), 0);
        chk("reset result", 32'(result_o), 0);
        chk("reset flags", 32'(flags_o), 0);
        chk("reset drop", 32'(drop_o), 0);
        @(negedge clk) begin rst = 1'b0; valid_i = 1'b0; end
        repeat (3) @(posedge clk);
        #1 chk("valid with rst ignored", 32'(valid_o), 0);

        for (int i = 0; i < 14; i++) apply(i, tv[i]);
        @(posedge clk) #1 chk("drained", 32'(valid_o), 0);

        // Overflow: A,B fill the FIFO, C is dropped, then drain A,B
        @(negedge clk) ready_i = 1'b0;
        burst(A, B, C);
        @(negedge clk) valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk) #1;
        chk("full drop", 32'(drop_o), 1);
        chk("full head A", 32'(result_o), 32'(A.res));
        chk("full valid", 32'(valid_o), 1);
        @(negedge clk) ready_i = 1'b1;
        @(posedge clk) #1 chk("pop head B", 32'(result_o), 32'(B.res));
        chk("pop flags B", 32'(flags_o), 32'(B.flg));
        @(posedge clk) #1 chk("empty after B", 32'(valid_o), 0);
        chk("drop sticky", 32'(drop_o), 1);
        chk("empty result", 32'(result_o), 0);

        // Push and pop together while full: no drop
        @(negedge clk) begin rst = 1'b1; ready_i = 1'b0; end
        @(negedge clk) rst = 1'b0;
        chk("drop cleared", 32'(drop_o), 0);
        burst(A, B, C);
        @(negedge clk) valid_i = 1'b0;
        @(negedge clk) ready_i = 1'b1;
        @(posedge clk) #1;
        chk("push+pop head B", 32'(result_o), 32'(B.res));
        chk("push+pop no drop", 32'(drop_o), 0);
        @(posedge clk) #1 chk("push+pop head C", 32'(result_o), 32'(C.res));
        @(posedge clk) #1 chk("push+pop drained", 32'(valid_o), 0);
        chk("push+pop drop", 32'(drop_o), 0);

        // Reset with A in FIFO, B and C in the pipeline, plus a coincident valid_i
        @(negedge clk) ready_i = 1'b0;
        burst(A, B, C);
        @(posedge clk) #1 chk("pre-reset head A", 32'(result_o), 32'(A.res));
        @(negedge clk) begin rst = 1'b1; drive(B); end
        @(posedge clk) #1;
        chk("rst valid", 32'(valid_o), 0);
        chk("rst result", 32'(result_o), 0);
        chk("rst drop", 32'(drop_o), 0);
        @(negedge clk) begin rst = 1'b0; valid_i = 1'b0; ready_i = 1'b1; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1 chk($sformatf("post-rst idle %0d", i), 32'(valid_o), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule

// File: doc/lamp_fpu_sqrt_round_out.md
Name: lamp_fpu_sqrt_round_out

Overview:
- Downstream stage of the lampFPU square-root unit.
- Consumes the registered pre-rounded result of the sqrt/inverse-sqrt datapath: sign, 8-bit exponent, and 12-bit extended mantissa with guard/sticky bits.
- Applies rounding, handles mantissa carry into the exponent, detects overflow, and packs a BFloat16 word.
- Buffers completed results in a small FIFO with valid/ready handshake towards the consumer (register file / writeback).

Parameters:
- FIFO_DEPTH, 2, number of packed results buffered; power of two, ≥2.
- E_DW, 8, exponent width (LAMP_FLOAT_E_DW).
- F_DW, 7, stored fraction width (LAMP_FLOAT_F_DW).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  one-cycle pulse: result inputs valid
- s_i  in  1  result sign
- e_i  in  E_DW  normalized result exponent
- f_i  in  F_DW+5  {hidden, fraction[F_DW], G, x, x, S}; bits [2:0] OR'd as sticky
- isToRound_i  in  1  1 = numeric result to round; 0 = special (zero/inf/NaN) pass-through
- isOverflow_i  in  1  upstream overflow indication
- isUnderflow_i  in  1  upstream underflow indication
- ready_i  in  1  consumer accepts head entry
- valid_o  out  1  FIFO non-empty
- result_o  out  1+E_DW+F_DW  packed {s,e,frac} of head entry
- flags_o  out  3  {overflow, underflow, inexact} of head entry
- drop_o  out  1  sticky: a result was lost because the FIFO was full

Behaviour:
- Reset (rst=1 at a clock edge):
  - valid_o=0, result_o=0, flags_o=0, drop_o=0.
  - Both pipeline valids cleared; FIFO pointers and count zeroed.
  - Any in-flight result is discarded. A valid_i coincident with rst is ignored.
- Pipeline, fixed latency 2:
  - valid_i sampled at edge N.
  - Stage 1 (registered at N+1): mant=f_i[11:4], G=f_i[3], S=|f_i[2:0].
    - Default RNE: inc = G & (S | mant[0]).
    - sum = {1'b0, mant} + inc, 9 bits.
    - Register s, e, sum, G|S, isToRound, isOverflow, isUnderflow.
  - Stage 2 (written to FIFO at N+2), when isToRound=1:
    - If sum[8]=1: frac=sum[8:1] minus hidden bit (i.e. frac=0), e=e+1.
    - Else frac=sum[6:0].
    - If the resulting e == 8'hFF: pack as infinity {s, 8'hFF, 7'h0} and set overflow.
    - inexact = G|S.
    - overflow |= isOverflow_i; underflow = isUnderflow_i.
  - Stage 2, when isToRound=0:
    - result = {s, e_i, f_i[10:4]} unchanged; flags=0.
  - Entry becomes visible on valid_o in the cycle after the write. Earliest valid_o: cycle N+2 after sampling at N.
- Pipeline is non-stalling: accepts valid_i every cycle, independent of ready_i.
- FIFO:
  - Pop when valid_o & ready_i. result_o/flags_o always reflect the head entry; 0 when empty.
  - Push when stage 2 valid.
  - Push & pop in the same cycle when full: both occur, count unchanged, no drop.
  - Push when full without pop: entry discarded, FIFO unchanged, drop_o set and held until rst.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; ordering strictly FIFO.
- No combinational path from any input to any output.

Optional Feature:
- Macro LAMP_SQRT_RND_MODES_EN.
- When defined, adds input port rnd_mode_i [1:0], sampled with valid_i:
  - 00 RNE (as above)
  - 01 RTZ: inc=0
  - 10 RUP: inc=(G|S)&~s
  - 11 RDN: inc=(G|S)&s
- Overflow under RTZ, or under RUP/RDN when the sign opposes the rounding direction, packs max-finite {s, 8'hFE, 7'h7F} instead of infinity; overflow flag still set.
- When undefined: port absent, RNE only.

Test Plan:
- s=0,e=0x80,f=0x800,isToRound=1, ready_i=1 -> result_o=0x4000, flags=000, valid_o 2 cycles after valid_i.
- e=0x7F,f=0x818 -> 0x3F82, inexact=1; e=0x7F,f=0x808 (tie, even) -> 0x3F80, inexact=1.
- e=0x7F,f=0xFF8 -> carry: 0x4000, inexact=1; e=0xFE,f=0xFF8 -> 0x7F80, flags=101.
- isToRound=0,s=0,e=0xFF,f=0xC00 -> 0x7FC0, flags=000; isToRound=0,s=1,e=0,f=0 -> 0x8000.
- ready_i=0, three results on back-to-back valid_i (A,B,C), FIFO_DEPTH=2 -> C dropped, drop_o=1; then ready_i=1 -> pops A then B, valid_o falls; drop_o stays 1.
- Assert rst while two results are in the pipeline and one is in the FIFO -> valid_o=0 the next cycle, no entries emerge afterwards, drop_o=0.
